l2_input_select: RTL and testbench

Front-end arbiter and stall tracker for the L2 request buffer. Each cycle it picks one input channel by fixed priority: response, forward, CPU request, flush. It drives the buffer's lookup/peek opcode and `lookup_en`, then latches the buffer's set-conflict and forward-stall pulses into sticky flags. One cycle later it issues the selected transaction, with the buffer index, to the L2 FSM. It also tracks buffer occupancy, so requests and flushes are never admitted when no entry is free.

---
 rtl/l2_input_select.sv | 178 +++++++++++++++++
 tb/tb_l2_input_select.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_input_select.sv
// Fixed-priority front end for the L2 request buffer (rsp > fwd > req > flush). It grants
// in IDLE and issues the next cycle; the issue holds while issue_ready is low, and stalled req/fwd channels are not issued.
module l2_input_select #(
    parameter int N_REQS    = 4,
    parameter int REQS_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsp_valid,
    input  logic                 fwd_valid,
    input  logic                 req_valid,
    input  logic                 flush_valid,
    output logic                 rsp_ready,
    output logic                 fwd_ready,
    output logic                 req_ready,
    output logic                 flush_ready,
    input  logic                 set_set_conflict,
    input  logic                 clr_set_conflict,
    input  logic                 set_fwd_stall,
    input  logic                 clr_fwd_stall,
    input  logic                 set_fwd_stall_i,
    input  logic [REQS_BITS-1:0] fwd_stall_i_wr_data,
    input  logic [REQS_BITS-1:0] reqs_i,
    input  logic                 reqs_hit,
    input  logic                 reqs_free,
    output logic [2:0]           reqs_op_code,
    output logic                 lookup_en,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [1:0]           issue_kind,
    output logic [REQS_BITS-1:0] issue_reqs_i,
    output logic                 issue_hit,
    output logic                 set_conflict,
    output logic                 fwd_stall,
    output logic [REQS_BITS-1:0] fwd_stall_i,
    output logic [REQS_BITS:0]   reqs_cnt,
    output logic                 reqs_full
);

    localparam logic [2:0] L2_REQS_IDLE       = 3'd0;
    localparam logic [2:0] L2_REQS_LOOKUP     = 3'd1;
    localparam logic [2:0] L2_REQS_PEEK_REQ   = 3'd2;
    localparam logic [2:0] L2_REQS_PEEK_FWD   = 3'd3;
    localparam logic [2:0] L2_REQS_PEEK_FLUSH = 3'd4;

    localparam logic [REQS_BITS:0] FULL_CNT = (REQS_BITS+1)'(N_REQS);
    localparam logic [REQS_BITS:0] CNT_ONE  = (REQS_BITS+1)'(1);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic [1:0] {KIND_RSP, KIND_FWD, KIND_REQ, KIND_FLUSH} kind_t;

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;
    logic                   set_conflict_q, set_conflict_d;
    logic                   fwd_stall_q, fwd_stall_d;
    logic [REQS_BITS-1:0]   fwd_stall_i_q, fwd_stall_i_d;
    logic [REQS_BITS-1:0]   rsp_idx_q, rsp_idx_d;
    logic [REQS_BITS:0]     reqs_cnt_q, reqs_cnt_d;

    logic                   full;
    logic                   grant;
    kind_t                  grant_kind;
    logic [2:0]             grant_op;
    logic                   in_idle;
    logic                   in_issue;
    logic                   stalled;
    logic                   fire;
    logic                   alloc;
    logic                   free_eff;

    assign full = (reqs_cnt_q == FULL_CNT);

    always_comb begin
        grant      = 1'b0;
        grant_kind = KIND_RSP;
        grant_op   = L2_REQS_IDLE;
        if (rsp_valid) begin
            grant      = 1'b1;
            grant_kind = KIND_RSP;
            grant_op   = L2_REQS_LOOKUP;
        end else if (fwd_valid && !fwd_stall_q) begin
            grant      = 1'b1;
            grant_kind = KIND_FWD;
            grant_op   = L2_REQS_PEEK_FWD;
        end else if (req_valid && !set_conflict_q && !full) begin
            grant      = 1'b1;
            grant_kind = KIND_REQ;
            grant_op   = L2_REQS_PEEK_REQ;
        end else if (flush_valid && !full) begin
            grant      = 1'b1;
            grant_kind = KIND_FLUSH;
            grant_op   = L2_REQS_PEEK_FLUSH;
        end
    end

    assign in_idle  = (state_q == IDLE) && !rst;
    assign in_issue = (state_q == ISSUE);
    // Flags were loaded on the grant edge, so they already reflect the peek result here.
    assign stalled  = (kind_q == KIND_REQ && set_conflict_q) || (kind_q == KIND_FWD && fwd_stall_q);
    assign fire     = in_issue && !stalled && issue_ready && !rst;
    assign alloc    = fire && (kind_q == KIND_REQ || kind_q == KIND_FLUSH);
    assign free_eff = reqs_free && (reqs_cnt_q != '0);

    assign lookup_en    = in_idle && grant;
    assign reqs_op_code = (in_idle && grant) ? grant_op : L2_REQS_IDLE;
    assign issue_valid  = in_issue && !stalled;
    assign issue_kind   = kind_q;
    assign issue_reqs_i = in_issue ? reqs_i : '0;
    assign issue_hit    = in_issue && reqs_hit;
    assign rsp_ready    = fire && (kind_q == KIND_RSP);
    assign fwd_ready    = fire && (kind_q == KIND_FWD);
    assign req_ready    = fire && (kind_q == KIND_REQ);
    assign flush_ready  = fire && (kind_q == KIND_FLUSH);
    assign set_conflict = set_conflict_q;
    assign fwd_stall    = fwd_stall_q;
    assign fwd_stall_i  = fwd_stall_i_q;
    assign reqs_cnt     = reqs_cnt_q;
    assign reqs_full    = full;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    kind_d  = grant_kind;
                end
            end
            ISSUE: begin
                if (stalled || issue_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_idx_d     = (fire && kind_q == KIND_RSP) ? reqs_i : rsp_idx_q;
        fwd_stall_i_d = set_fwd_stall_i ? fwd_stall_i_wr_data : fwd_stall_i_q;

        set_conflict_d = set_conflict_q;
        if (set_set_conflict)                        set_conflict_d = 1'b1;
        else if (clr_set_conflict || reqs_free)      set_conflict_d = 1'b0;

        // The forward-stall entry is recognised as freed by matching the last response index.
        fwd_stall_d = fwd_stall_q;
        if (set_fwd_stall)                           fwd_stall_d = 1'b1;
        else if (clr_fwd_stall || (reqs_free && fwd_stall_i_q == rsp_idx_q))
                                                     fwd_stall_d = 1'b0;

        unique case ({alloc, free_eff})
            2'b10:   reqs_cnt_d = reqs_cnt_q + CNT_ONE;
            2'b01:   reqs_cnt_d = reqs_cnt_q - CNT_ONE;
            default: reqs_cnt_d = reqs_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            kind_q         <= KIND_RSP;
            set_conflict_q <= 1'b0;
            fwd_stall_q    <= 1'b0;
            fwd_stall_i_q  <= '0;
            rsp_idx_q      <= '0;
            reqs_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            set_conflict_q <= set_conflict_d;
            fwd_stall_q    <= fwd_stall_d;
            fwd_stall_i_q  <= fwd_stall_i_d;
            rsp_idx_q      <= rsp_idx_d;
            reqs_cnt_q     <= reqs_cnt_d;
        end
    end

endmodule

// File: tb/tb_l2_input_select.sv
// Directed bench for l2_input_select: inputs change on the falling edge, outputs are checked 1ns later.
module tb_l2_input_select;

    localparam logic [2:0] OP_IDLE   = 3'd0;
    localparam logic [2:0] OP_LOOKUP = 3'd1;
    localparam logic [2:0] OP_REQ    = 3'd2;
    localparam logic [2:0] OP_FWD    = 3'd3;
    localparam logic [2:0] OP_FLUSH  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsp_valid, fwd_valid, req_valid, flush_valid;
    logic       rsp_ready, fwd_ready, req_ready, flush_ready;
    logic       set_set_conflict, clr_set_conflict, set_fwd_stall, clr_fwd_stall;
    logic       set_fwd_stall_i;
    logic [1:0] fwd_stall_i_wr_data;
    logic [1:0] reqs_i;
    logic       reqs_hit;
    logic       reqs_free;
    logic [2:0] reqs_op_code;
    logic       lookup_en;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] issue_kind;
    logic [1:0] issue_reqs_i;
    logic       issue_hit;
    logic       set_conflict, fwd_stall;
    logic [1:0] fwd_stall_i;
    logic [2:0] reqs_cnt;
    logic       reqs_full;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l2_input_select #(.N_REQS(4), .REQS_BITS(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rsp_valid           (rsp_valid),
        .fwd_valid           (fwd_valid),
        .req_valid           (req_valid),
        .flush_valid         (flush_valid),
        .rsp_ready           (rsp_ready),
        .fwd_ready           (fwd_ready),
        .req_ready           (req_ready),
        .flush_ready         (flush_ready),
        .set_set_conflict    (set_set_conflict),
        .clr_set_conflict    (clr_set_conflict),
        .set_fwd_stall       (set_fwd_stall),
        .clr_fwd_stall       (clr_fwd_stall),
        .set_fwd_stall_i     (set_fwd_stall_i),
        .fwd_stall_i_wr_data (fwd_stall_i_wr_data),
        .reqs_i              (reqs_i),
        .reqs_hit            (reqs_hit),
        .reqs_free           (reqs_free),
        .reqs_op_code        (reqs_op_code),
        .lookup_en           (lookup_en),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_kind          (issue_kind),
        .issue_reqs_i        (issue_reqs_i),
        .issue_hit           (issue_hit),
        .set_conflict        (set_conflict),
        .fwd_stall           (fwd_stall),
        .fwd_stall_i         (fwd_stall_i),
        .reqs_cnt            (reqs_cnt),
        .reqs_full           (reqs_full)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_readies(input string tag, input logic [3:0] exp);
        chk(tag, 8'({rsp_ready, fwd_ready, req_ready, flush_ready}), 8'(exp));
    endtask

    initial begin
        rst = 1'b1;
        {rsp_valid, fwd_valid, req_valid, flush_valid} = 4'b0;
        {set_set_conflict, clr_set_conflict, set_fwd_stall, clr_fwd_stall} = 4'b0;
        set_fwd_stall_i = 1'b0;
        fwd_stall_i_wr_data = 2'd0;
        reqs_i = 2'd0;
        reqs_hit = 1'b0;
        reqs_free = 1'b0;
        issue_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_op", 8'(reqs_op_code), 8'(OP_IDLE));
        chk("rst_lookup", 8'(lookup_en), 8'd0);
        chk("rst_issue_valid", 8'(issue_valid), 8'd0);
        chk("rst_kind", 8'(issue_kind), 8'd0);
        chk_readies("rst_readies", 4'b0000);
        chk("rst_cnt", 8'(reqs_cnt), 8'd0);
        chk("rst_full", 8'(reqs_full), 8'd0);
        chk("rst_flags", 8'({set_conflict, fwd_stall, fwd_stall_i}), 8'd0);

        // Single request: peek at T, issue + ready at T+1, count at T+2
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b1; issue_ready = 1'b1; reqs_i = 2'd2; reqs_hit = 1'b1;
        #1;
        chk("t1_op", 8'(reqs_op_code), 8'(OP_REQ));
        chk("t1_lookup", 8'(lookup_en), 8'd1);
        @(negedge clk); #1;
        chk("t1_issue_valid", 8'(issue_valid), 8'd1);
        chk("t1_kind", 8'(issue_kind), 8'd2);
        chk("t1_idx", 8'(issue_reqs_i), 8'd2);
        chk("t1_hit", 8'(issue_hit), 8'd1);
        chk_readies("t1_ready", 4'b0010);
        chk("t1_lookup_issue", 8'(lookup_en), 8'd0);
        @(negedge clk);
        req_valid = 1'b0; reqs_hit = 1'b0;
        #1;
        chk("t1_cnt", 8'(reqs_cnt), 8'd1);
        chk("t1_idle_valid", 8'(issue_valid), 8'd0);

        // All four channels at once: rsp, fwd, req, flush in order
        @(negedge clk);
        {rsp_valid, fwd_valid, req_valid, flush_valid} = 4'b1111; reqs_i = 2'd1;
        #1;
        chk("t2_op_rsp", 8'(reqs_op_code), 8'(OP_LOOKUP));
        @(negedge clk); #1;
        chk("t2_kind_rsp", 8'(issue_kind), 8'd0);
        chk_readies("t2_ready_rsp", 4'b1000);
        @(negedge clk); rsp_valid = 1'b0; #1;
        chk("t2_op_fwd", 8'(reqs_op_code), 8'(OP_FWD));
        @(negedge clk); #1;
        chk("t2_kind_fwd", 8'(issue_kind), 8'd1);
        chk_readies("t2_ready_fwd", 4'b0100);
        @(negedge clk); fwd_valid = 1'b0; #1;
        chk("t2_op_req", 8'(reqs_op_code), 8'(OP_REQ));
        @(negedge clk); #1;
        chk("t2_kind_req", 8'(issue_kind), 8'd2);
        chk_readies("t2_ready_req", 4'b0010);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("t2_op_flush", 8'(reqs_op_code), 8'(OP_FLUSH));
        chk("t2_cnt2", 8'(reqs_cnt), 8'd2);
        @(negedge clk); #1;
        chk("t2_kind_flush", 8'(issue_kind), 8'd3);
        chk_readies("t2_ready_flush", 4'b0001);
        @(negedge clk); flush_valid = 1'b0; #1;
        chk("t2_cnt3", 8'(reqs_cnt), 8'd3);
        chk("t2_op_idle", 8'(reqs_op_code), 8'(OP_IDLE));

        // Set conflict on the peek: stalled, blocked, released by reqs_free
        @(negedge clk); req_valid = 1'b1; set_set_conflict = 1'b1; #1;
        chk("t3_op", 8'(reqs_op_code), 8'(OP_REQ));
        @(negedge clk); set_set_conflict = 1'b0; #1;
        chk("t3_conflict", 8'(set_conflict), 8'd1);
        chk("t3_no_issue", 8'(issue_valid), 8'd0);
        chk_readies("t3_no_ready", 4'b0000);
        @(negedge clk); #1;
        chk("t3_blocked", 8'(reqs_op_code), 8'(OP_IDLE));
        chk("t3_blocked_lookup", 8'(lookup_en), 8'd0);
        @(negedge clk); reqs_free = 1'b1; #1;
        chk("t3_blocked2", 8'(reqs_op_code), 8'(OP_IDLE));
        @(negedge clk); reqs_free = 1'b0; #1;
        chk("t3_conflict_clr", 8'(set_conflict), 8'd0);
        chk("t3_regrant", 8'(reqs_op_code), 8'(OP_REQ));
        chk("t3_cnt2", 8'(reqs_cnt), 8'd2);
        @(negedge clk); #1;
        chk_readies("t3_ready", 4'b0010);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("t3_cnt3", 8'(reqs_cnt), 8'd3);

        // Occupancy: allocate+free together, then fill, gating, free
        @(negedge clk); req_valid = 1'b1; #1;
        chk("t4_op", 8'(reqs_op_code), 8'(OP_REQ));
        @(negedge clk); reqs_free = 1'b1; #1;
        chk_readies("t4_ready_a", 4'b0010);
        @(negedge clk); reqs_free = 1'b0; #1;
        chk("t4_cnt_same", 8'(reqs_cnt), 8'd3);
        chk("t4_not_full", 8'(reqs_full), 8'd0);
        chk("t4_op2", 8'(reqs_op_code), 8'(OP_REQ));
        @(negedge clk); #1;
        chk_readies("t4_ready_b", 4'b0010);
        @(negedge clk); flush_valid = 1'b1; #1;
        chk("t4_cnt4", 8'(reqs_cnt), 8'd4);
        chk("t4_full", 8'(reqs_full), 8'd1);
        chk("t4_gated_op", 8'(reqs_op_code), 8'(OP_IDLE));
        chk("t4_gated_lookup", 8'(lookup_en), 8'd0);
        @(negedge clk); reqs_free = 1'b1; #1;
        chk("t4_gated_op2", 8'(reqs_op_code), 8'(OP_IDLE));
        @(negedge clk); reqs_free = 1'b0; req_valid = 1'b0; flush_valid = 1'b0; #1;
        chk("t4_cnt_free", 8'(reqs_cnt), 8'd3);
        chk("t4_full_clr", 8'(reqs_full), 8'd0);

        // Forward stall on index 2: free of another entry does not clear, clr_fwd_stall does
        @(negedge clk);
        fwd_valid = 1'b1; set_fwd_stall = 1'b1; set_fwd_stall_i = 1'b1; fwd_stall_i_wr_data = 2'd2;
        #1;
        chk("t5_op", 8'(reqs_op_code), 8'(OP_FWD));
        @(negedge clk); set_fwd_stall = 1'b0; set_fwd_stall_i = 1'b0; #1;
        chk("t5_stall", 8'(fwd_stall), 8'd1);
        chk("t5_stall_i", 8'(fwd_stall_i), 8'd2);
        chk("t5_no_issue", 8'(issue_valid), 8'd0);
        chk_readies("t5_no_ready", 4'b0000);
        @(negedge clk); reqs_free = 1'b1; #1;
        chk("t5_held", 8'(reqs_op_code), 8'(OP_IDLE));
        @(negedge clk); reqs_free = 1'b0; clr_fwd_stall = 1'b1; #1;
        chk("t5_stall_kept", 8'(fwd_stall), 8'd1);
        chk("t5_cnt2", 8'(reqs_cnt), 8'd2);
        chk("t5_held2", 8'(reqs_op_code), 8'(OP_IDLE));
        @(negedge clk); clr_fwd_stall = 1'b0; #1;
        chk("t5_stall_clr", 8'(fwd_stall), 8'd0);
        chk("t5_regrant", 8'(reqs_op_code), 8'(OP_FWD));
        @(negedge clk); #1;
        chk_readies("t5_ready", 4'b0100);
        chk("t5_kind", 8'(issue_kind), 8'd1);

        // Forward stall on index 1 (last rsp index): freeing that entry clears it
        @(negedge clk);
        set_fwd_stall = 1'b1; set_fwd_stall_i = 1'b1; fwd_stall_i_wr_data = 2'd1;
        #1;
        chk("t5b_op", 8'(reqs_op_code), 8'(OP_FWD));
        @(negedge clk); set_fwd_stall = 1'b0; set_fwd_stall_i = 1'b0; #1;
        chk("t5b_stall_i", 8'(fwd_stall_i), 8'd1);
        chk("t5b_stall", 8'(fwd_stall), 8'd1);
        chk("t5b_no_issue", 8'(issue_valid), 8'd0);
        @(negedge clk); reqs_free = 1'b1; #1;
        chk("t5b_held", 8'(reqs_op_code), 8'(OP_IDLE));
        @(negedge clk); reqs_free = 1'b0; #1;
        chk("t5b_stall_clr", 8'(fwd_stall), 8'd0);
        chk("t5b_cnt1", 8'(reqs_cnt), 8'd1);
        chk("t5b_regrant", 8'(reqs_op_code), 8'(OP_FWD));
        @(negedge clk); #1;
        chk_readies("t5b_ready", 4'b0100);

        // Back-pressure for 5 cycles, then reset mid-issue
        @(negedge clk);
        fwd_valid = 1'b0; req_valid = 1'b1; issue_ready = 1'b0; reqs_i = 2'd3;
        #1;
        chk("t6_op", 8'(reqs_op_code), 8'(OP_REQ));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t6_hold_valid", 8'(issue_valid), 8'd1);
            chk("t6_hold_idx", 8'(issue_reqs_i), 8'd3);
            chk_readies("t6_hold_ready", 4'b0000);
        end
        @(negedge clk); rst = 1'b1; issue_ready = 1'b1; #1;
        chk_readies("t6_rst_ready", 4'b0000);
        @(negedge clk); rst = 1'b0; req_valid = 1'b0; issue_ready = 1'b0; #1;
        chk("t6_issue_valid", 8'(issue_valid), 8'd0);
        chk("t6_kind", 8'(issue_kind), 8'd0);
        chk("t6_idx", 8'(issue_reqs_i), 8'd0);
        chk("t6_cnt", 8'(reqs_cnt), 8'd0);
        chk("t6_flags", 8'({set_conflict, fwd_stall, fwd_stall_i}), 8'd0);
        chk("t6_op", 8'(reqs_op_code), 8'(OP_IDLE));
        chk_readies("t6_readies", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
